data_obi_arbiter: RTL and testbench

DATA_OBI_ARBITER -- requirements
Module: data_obi_arbiter

---
 rtl/data_obi_arbiter.sv | 105 ++++++++++
 tb/tb_data_obi_arbiter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/data_obi_arbiter.sv
// Two-requester OBI data-port arbiter: round-robin with a lock that holds the
// request until it is granted, and an ID FIFO that routes responses back in order.
module data_obi_arbiter #(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  req_i,
  output logic [1:0]  gnt_o,
  output logic [1:0]  rvalid_o,
  input  logic [1:0]  we_i,
  input  logic [7:0]  be_i,
  input  logic [63:0] addr_i,
  input  logic [63:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        data_req_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic [31:0] data_rdata_i,
  output logic        err_o
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  logic             lock_q;
  logic             lock_sel_q;
  logic             prio_q;
  logic             err_q;
  logic [PTR_W-1:0] wptr_q;
  logic [PTR_W-1:0] rptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             id_q [MAX_OUTSTANDING];

  logic sel;
  logic full;
  logic empty;
  logic push;
  logic pop;
  logic head;

  // A pending (ungranted) request keeps its requester selected until granted.
  always_comb begin
    sel = 1'b0;
    if (lock_q)              sel = lock_sel_q;
    else if (req_i == 2'b11) sel = prio_q;
    else                     sel = req_i[1];
  end

  assign full  = (cnt_q == CNT_MAX);
  assign empty = (cnt_q == '0);
  assign head  = id_q[rptr_q];

  assign data_req_o = req_i[sel] & ~full & ~rst_i;
  assign push       = data_req_o & data_gnt_i;
  assign pop        = data_rvalid_i & ~empty & ~rst_i;

  assign gnt_o    = {push & sel, push & ~sel};
  assign rvalid_o = {pop & head, pop & ~head};
  assign rdata_o  = data_rdata_i;
  assign err_o    = err_q;

  assign data_we_o    = sel ? we_i[1]         : we_i[0];
  assign data_be_o    = sel ? be_i[7:4]       : be_i[3:0];
  assign data_addr_o  = sel ? addr_i[63:32]   : addr_i[31:0];
  assign data_wdata_o = sel ? wdata_i[63:32]  : wdata_i[31:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_q     <= 1'b0;
      lock_sel_q <= 1'b0;
      prio_q     <= 1'b0;
      err_q      <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
    end else begin
      lock_q     <= data_req_o & ~data_gnt_i;
      lock_sel_q <= sel;
      if (push) begin
        prio_q <= ~sel;
        wptr_q <= ptr_next(wptr_q);
      end
      if (pop) rptr_q <= ptr_next(rptr_q);
      cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
      // Stray response or grant without a request is a protocol violation.
      if ((data_rvalid_i & empty) | (data_gnt_i & ~data_req_o)) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) id_q[wptr_q] <= sel;
  end

endmodule

// File: tb/tb_data_obi_arbiter.sv
// Directed bench for data_obi_arbiter: vector table on a depth-4 instance,
// hand-written full/simultaneous sequences on a depth-2 instance.
module tb_data_obi_arbiter;

  localparam logic [31:0] ADDR0  = 32'h0000_1000;
  localparam logic [31:0] ADDR1  = 32'h0000_2000;
  localparam logic [31:0] WDATA0 = 32'hAAAA_0000;
  localparam logic [31:0] WDATA1 = 32'hBBBB_1111;

  logic        clk;
  logic        rst;
  logic [1:0]  req;
  logic        gnt;
  logic        rv;
  logic [31:0] rdata;
  logic [1:0]  we;
  logic [7:0]  be;
  logic [63:0] addr;
  logic [63:0] wdata;

  logic [1:0]  gnt_a, rvalid_a, gnt_b, rvalid_b;
  logic [31:0] rdata_a, rdata_b, daddr_a, daddr_b, dwdata_a, dwdata_b;
  logic [3:0]  dbe_a, dbe_b;
  logic        dreq_a, dreq_b, dwe_a, dwe_b, err_a, err_b;

  int n_total = 0;
  int n_pass  = 0;

  data_obi_arbiter #(.MAX_OUTSTANDING(4)) dut_a (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt_a), .rvalid_o(rvalid_a),
    .we_i(we), .be_i(be), .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata_a),
    .data_req_o(dreq_a), .data_gnt_i(gnt), .data_rvalid_i(rv), .data_we_o(dwe_a),
    .data_be_o(dbe_a), .data_addr_o(daddr_a), .data_wdata_o(dwdata_a),
    .data_rdata_i(rdata), .err_o(err_a)
  );

  data_obi_arbiter #(.MAX_OUTSTANDING(2)) dut_b (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt_b), .rvalid_o(rvalid_b),
    .we_i(we), .be_i(be), .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata_b),
    .data_req_o(dreq_b), .data_gnt_i(gnt), .data_rvalid_i(rv), .data_we_o(dwe_b),
    .data_be_o(dbe_b), .data_addr_o(daddr_b), .data_wdata_o(dwdata_b),
    .data_rdata_i(rdata), .err_o(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [1:0]  req;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic [1:0]  e_gnt;
    logic [1:0]  e_rv;
    logic        e_dreq;
    logic        e_sel;
    logic        e_err;
  } vec_t;

  localparam int NV = 26;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic r, input logic [1:0] q, input logic g,
                              input logic v, input logic [31:0] d,
                              input logic [1:0] eg, input logic [1:0] ev,
                              input logic edq, input logic es, input logic ee);
    vec_t t;
    t.rst = r; t.req = q; t.gnt = g; t.rv = v; t.rdata = d;
    t.e_gnt = eg; t.e_rv = ev; t.e_dreq = edq; t.e_sel = es; t.e_err = ee;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    else
      n_pass++;
  endtask

  task automatic drive(input logic r, input logic [1:0] q, input logic g,
                       input logic v, input logic [31:0] d);
    rst = r; req = q; gnt = g; rv = v; rdata = d;
    #2;
  endtask

  task automatic chk_b(input string name, input logic [1:0] eg, input logic [1:0] ev,
                       input logic edq, input logic ee);
    chk({name, ".gnt"},    32'(gnt_b),    32'(eg));
    chk({name, ".rvalid"}, 32'(rvalid_b), 32'(ev));
    chk({name, ".dreq"},   32'(dreq_b),   32'(edq));
    chk({name, ".err"},    32'(err_b),    32'(ee));
    if (ev != 2'b00) chk({name, ".rdata"}, rdata_b, rdata);
  endtask

  initial begin
    string nm;
    tbl[0]  = mk(1, 2'b11, 1, 1, 32'h0,         2'b00, 2'b00, 0, 0, 0);
    tbl[1]  = mk(0, 2'b11, 1, 0, 32'h0,         2'b01, 2'b00, 1, 0, 0);
    tbl[2]  = mk(0, 2'b11, 1, 0, 32'h0,         2'b10, 2'b00, 1, 1, 0);
    tbl[3]  = mk(0, 2'b11, 1, 0, 32'h0,         2'b01, 2'b00, 1, 0, 0);
    tbl[4]  = mk(0, 2'b11, 1, 0, 32'h0,         2'b10, 2'b00, 1, 1, 0);
    tbl[5]  = mk(0, 2'b00, 0, 1, 32'h1111_1111, 2'b00, 2'b01, 0, 0, 0);
    tbl[6]  = mk(0, 2'b00, 0, 1, 32'h2222_2222, 2'b00, 2'b10, 0, 0, 0);
    tbl[7]  = mk(0, 2'b00, 0, 1, 32'h1234_5678, 2'b00, 2'b01, 0, 0, 0);
    tbl[8]  = mk(0, 2'b00, 0, 1, 32'h8765_4321, 2'b00, 2'b10, 0, 0, 0);
    tbl[9]  = mk(0, 2'b01, 1, 0, 32'h0,         2'b01, 2'b00, 1, 0, 0);
    tbl[10] = mk(0, 2'b01, 0, 0, 32'h0,         2'b00, 2'b00, 1, 0, 0);
    tbl[11] = mk(0, 2'b11, 0, 0, 32'h0,         2'b00, 2'b00, 1, 0, 0);
    tbl[12] = mk(0, 2'b11, 0, 0, 32'h0,         2'b00, 2'b00, 1, 0, 0);
    tbl[13] = mk(0, 2'b11, 1, 0, 32'h0,         2'b01, 2'b00, 1, 0, 0);
    tbl[14] = mk(0, 2'b10, 1, 1, 32'h3333_3333, 2'b10, 2'b01, 1, 1, 0);
    tbl[15] = mk(0, 2'b00, 0, 1, 32'h4444_4444, 2'b00, 2'b01, 0, 0, 0);
    tbl[16] = mk(0, 2'b00, 0, 1, 32'h5555_5555, 2'b00, 2'b10, 0, 0, 0);
    tbl[17] = mk(0, 2'b00, 0, 1, 32'h6666_6666, 2'b00, 2'b00, 0, 0, 0);
    tbl[18] = mk(0, 2'b00, 0, 0, 32'h0,         2'b00, 2'b00, 0, 0, 1);
    tbl[19] = mk(0, 2'b00, 1, 0, 32'h0,         2'b00, 2'b00, 0, 0, 1);
    tbl[20] = mk(0, 2'b11, 1, 0, 32'h0,         2'b01, 2'b00, 1, 0, 1);
    tbl[21] = mk(1, 2'b11, 1, 0, 32'h0,         2'b00, 2'b00, 0, 1, 1);
    tbl[22] = mk(0, 2'b00, 0, 1, 32'h7777_7777, 2'b00, 2'b00, 0, 0, 0);
    tbl[23] = mk(0, 2'b11, 0, 0, 32'h0,         2'b00, 2'b00, 1, 0, 1);
    tbl[24] = mk(0, 2'b11, 1, 0, 32'h0,         2'b01, 2'b00, 1, 0, 1);
    tbl[25] = mk(0, 2'b00, 0, 1, 32'h9999_0000, 2'b00, 2'b01, 0, 0, 1);

    we    = 2'b10;
    be    = 8'hF3;
    addr  = {ADDR1, ADDR0};
    wdata = {WDATA1, WDATA0};

    drive(1, 2'b00, 0, 0, 32'h0);
    @(negedge clk);
    @(negedge clk);

    // Vector table on the depth-4 instance
    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].rst, tbl[i].req, tbl[i].gnt, tbl[i].rv, tbl[i].rdata);
      nm = $sformatf("v%0d", i);
      chk({nm, ".gnt"},    32'(gnt_a),    32'(tbl[i].e_gnt));
      chk({nm, ".rvalid"}, 32'(rvalid_a), 32'(tbl[i].e_rv));
      chk({nm, ".dreq"},   32'(dreq_a),   32'(tbl[i].e_dreq));
      chk({nm, ".err"},    32'(err_a),    32'(tbl[i].e_err));
      chk({nm, ".addr"},   daddr_a,  tbl[i].e_sel ? ADDR1 : ADDR0);
      chk({nm, ".wdata"},  dwdata_a, tbl[i].e_sel ? WDATA1 : WDATA0);
      chk({nm, ".we"},     32'(dwe_a), 32'(tbl[i].e_sel));
      chk({nm, ".be"},     32'(dbe_a), tbl[i].e_sel ? 32'hF : 32'h3);
      if (tbl[i].e_rv != 2'b00) chk({nm, ".rdata"}, rdata_a, tbl[i].rdata);
      @(negedge clk);
    end

    // Depth-2 instance: fill, block, free a slot, refill
    drive(1, 2'b00, 0, 0, 32'h0);
    @(negedge clk);
    drive(0, 2'b01, 1, 0, 32'h0);          chk_b("f1", 2'b01, 2'b00, 1, 0); @(negedge clk);
    drive(0, 2'b01, 1, 0, 32'h0);          chk_b("f2", 2'b01, 2'b00, 1, 0); @(negedge clk);
    drive(0, 2'b01, 0, 0, 32'h0);          chk_b("f3", 2'b00, 2'b00, 0, 0); @(negedge clk);
    drive(0, 2'b01, 0, 1, 32'hCAFE_0001);  chk_b("f4", 2'b00, 2'b01, 0, 0); @(negedge clk);
    drive(0, 2'b01, 1, 0, 32'h0);          chk_b("f5", 2'b01, 2'b00, 1, 0); @(negedge clk);
    drive(0, 2'b01, 0, 0, 32'h0);          chk_b("f6", 2'b00, 2'b00, 0, 0); @(negedge clk);
    drive(0, 2'b00, 0, 1, 32'hCAFE_0002);  chk_b("f7", 2'b00, 2'b01, 0, 0); @(negedge clk);
    drive(0, 2'b00, 0, 1, 32'hCAFE_0003);  chk_b("f8", 2'b00, 2'b01, 0, 0); @(negedge clk);
    drive(0, 2'b00, 0, 0, 32'h0);          chk_b("f9", 2'b00, 2'b00, 0, 0); @(negedge clk);

    // Depth-2 instance: grant and response together with one outstanding
    drive(0, 2'b10, 1, 0, 32'h0);          chk_b("s1", 2'b10, 2'b00, 1, 0); @(negedge clk);
    drive(0, 2'b01, 1, 1, 32'hBEEF_0001);  chk_b("s2", 2'b01, 2'b10, 1, 0); @(negedge clk);
    drive(0, 2'b00, 0, 1, 32'hBEEF_0002);  chk_b("s3", 2'b00, 2'b01, 0, 0); @(negedge clk);
    drive(0, 2'b01, 0, 0, 32'h0);          chk_b("s4", 2'b00, 2'b00, 1, 0); @(negedge clk);
    drive(0, 2'b01, 1, 0, 32'h0);          chk_b("s5", 2'b01, 2'b00, 1, 0); @(negedge clk);
    drive(0, 2'b01, 1, 0, 32'h0);          chk_b("s6", 2'b01, 2'b00, 1, 0); @(negedge clk);
    drive(0, 2'b01, 0, 0, 32'h0);          chk_b("s7", 2'b00, 2'b00, 0, 0); @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
